dmem_cache: RTL

- Direct-mapped, write-through, read-allocate data cache placed between the 5-stage core's data-memory port and the slower backing RAM bus.
- Serves load hits in the same cycle.
- On read misses, fills whole lines from the external bus. Stores are always written through.
- Generates ram_stall and ram_cs, which the core's controller uses to freeze the pipeline.

---
 rtl/dmem_cache_pkg.sv | 20 ++
 rtl/dmem_cache_array.sv | 51 +++++
 rtl/dmem_cache.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmem_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// controller state encoding, default geometry and address helpers.
package dmem_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_UCRD  = 2'd3
  } state_t;

  localparam int         DEF_LINE_WORDS = 4;
  localparam int         DEF_LINES      = 64;
  localparam logic [3:0] DEF_UC_BASE    = 4'hF;

  function automatic logic [31:0] word_addr(input logic [29:0] w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_cache_array.sv
// Valid/tag/data storage for the cache: asynchronous read port, one
// synchronous word write port, line-valid set, and async clear of valid bits.
module dmem_cache_array #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64,
  parameter int OFF_W      = 2,
  parameter int IDX_W      = 6,
  parameter int TAG_W      = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             set_valid,
  input  logic [TAG_W-1:0] set_tag
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES][LINE_WORDS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx][rd_off];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (set_valid) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents need no reset; a line is only trusted once valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data[wr_idx][wr_off] <= wr_data;
    end
    if (set_valid) begin
      tags[wr_idx] <= set_tag;
    end
  end

endmodule

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, read-allocate data cache between the core's
// data port and the backing RAM bus; drives the pipeline stall.
module dmem_cache
  import dmem_cache_pkg::*;
#(
  parameter int         LINE_WORDS = DEF_LINE_WORDS,
  parameter int         LINES      = DEF_LINES,
  parameter logic [3:0] UC_BASE    = DEF_UC_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        ram_stall,
  output logic        ram_cs,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ack,
  output logic [1:0]  state_dbg
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  state_t           state;
  logic [OFF_W-1:0] fill_cnt;
  logic [29:0]      look_word;
  logic [OFF_W-1:0] look_off;
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_data;
  logic             hit, is_store, is_load, cpu_uc, ext_uc;
  logic             arr_we, arr_set;
  logic [OFF_W-1:0] arr_off;
  logic [31:0]      arr_wdata;
  logic             unused_ok;

  // In IDLE the array is probed with the core address; in every other state
  // it is addressed by the latched bus address.
  assign look_word = (state == S_IDLE) ? cpu_addr[31:2] : ext_addr[31:2];
  assign look_off  = look_word[OFF_W-1:0];
  assign look_idx  = look_word[OFF_W+IDX_W-1:OFF_W];
  assign look_tag  = look_word[29:OFF_W+IDX_W];
  assign hit       = line_valid && (line_tag == look_tag);
  assign is_store  = cpu_wen;
  assign is_load   = cpu_ren && !cpu_wen;
  assign cpu_uc    = (cpu_addr[31:28] == UC_BASE);
  assign ext_uc    = (ext_addr[31:28] == UC_BASE);
  assign ram_cs    = cpu_ren | cpu_wen;
  assign state_dbg = state;
  assign unused_ok = ^cpu_addr[1:0];

  assign arr_we    = ext_ack && ((state == S_FILL) ||
                                 ((state == S_WRITE) && !ext_uc && hit));
  assign arr_set   = ext_ack && (state == S_FILL) && (fill_cnt == LAST_WORD);
  assign arr_off   = (state == S_FILL) ? fill_cnt : look_off;
  assign arr_wdata = (state == S_FILL) ? ext_rdata : ext_wdata;

  dmem_cache_array #(
    .LINE_WORDS (LINE_WORDS),
    .LINES      (LINES),
    .OFF_W      (OFF_W),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (look_idx),
    .rd_off    (look_off),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (arr_we),
    .wr_idx    (look_idx),
    .wr_off    (arr_off),
    .wr_data   (arr_wdata),
    .set_valid (arr_set),
    .set_tag   (look_tag)
  );

  always_comb begin
    ram_stall = 1'b0;
    cpu_rdata = '0;
    case (state)
      S_IDLE: begin
        if (is_store || (is_load && (cpu_uc || !hit))) begin
          ram_stall = 1'b1;
        end else if (is_load) begin
          cpu_rdata = line_data;
        end
      end
      S_FILL:  ram_stall = 1'b1;
      S_WRITE: ram_stall = !ext_ack;
      S_UCRD: begin
        ram_stall = !ext_ack;
        if (ext_ack) begin
          cpu_rdata = ext_rdata;
        end
      end
      default: ram_stall = 1'b1;
    endcase
  end

  // Bus handshake: ext_req is the valid; it rises with address/data already
  // stable, holds them unchanged, and is released only on the cycle after a
  // one-cycle ext_ack (the ready). A fill chains words by moving ext_addr on
  // each ack while keeping ext_req high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      fill_cnt  <= '0;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_store) begin
            state     <= S_WRITE;
            ext_req   <= 1'b1;
            ext_we    <= 1'b1;
            ext_addr  <= word_addr(cpu_addr[31:2]);
            ext_wdata <= cpu_wdata;
          end else if (is_load && cpu_uc) begin
            state    <= S_UCRD;
            ext_req  <= 1'b1;
            ext_we   <= 1'b0;
            ext_addr <= word_addr(cpu_addr[31:2]);
          end else if (is_load && !hit) begin
            state    <= S_FILL;
            fill_cnt <= '0;
            ext_req  <= 1'b1;
            ext_we   <= 1'b0;
            ext_addr <= word_addr({cpu_addr[31:OFF_W+2], {OFF_W{1'b0}}});
          end
        end
        S_FILL: begin
          if (ext_ack) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == LAST_WORD) begin
              state   <= S_IDLE;
              ext_req <= 1'b0;
            end else begin
              ext_addr <= ext_addr + 32'd4;
            end
          end
        end
        S_WRITE, S_UCRD: begin
          if (ext_ack) begin
            state   <= S_IDLE;
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
